// File: rtl/ibuff_queue.sv
`default_nettype none
// ibuff_queue: circular instruction buffer with compacting multi-lane push and a head read window.
// Rev 1.0

module ibuff_queue #(
  parameter int FETCH_WIDTH    = 2,
  parameter int DISPATCH_WIDTH = 4,
  parameter int WPORT          = 2 * FETCH_WIDTH,
  parameter int RPORT          = DISPATCH_WIDTH,
  parameter int DEPTH          = 16,
  parameter int INDEX          = 4,
  parameter int WIDTH          = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic [WPORT-1:0]             wr_valid_i,
  input  logic [WPORT*WIDTH-1:0]       wr_data_i,
  output logic                         stall_o,
  input  logic [$clog2(RPORT+1)-1:0]   pop_cnt_i,
  output logic [RPORT*WIDTH-1:0]       rd_data_o,
  output logic [RPORT-1:0]             rd_valid_o,
  output logic [INDEX:0]               count_o,
  output logic                         empty_o
);

  localparam logic [INDEX+1:0] c_depth = (INDEX+2)'(DEPTH);
  localparam logic [INDEX+1:0] c_wport = (INDEX+2)'(WPORT);
  localparam logic [INDEX:0]   c_rport = (INDEX+1)'(RPORT);

  logic [INDEX-1:0] r_head;
  logic [INDEX-1:0] r_tail;
  logic [INDEX:0]   r_count;
  logic [WIDTH-1:0] r_ram [DEPTH];

  logic [INDEX+1:0] w_free;
  logic             w_stall;
  logic             w_push;
  logic [INDEX-1:0] w_offset [WPORT];
  logic [INDEX:0]   w_nvalid;
  logic [INDEX:0]   w_npush;
  logic [INDEX:0]   w_pop_req;
  logic [INDEX:0]   w_npop;

  // Stall looks only at registered occupancy so it never depends on this cycle's pop.
  always_comb begin
    w_free  = c_depth - {1'b0, r_count};
    w_stall = (w_free < c_wport);
  end

  // Each valid lane lands at tail + (number of valid lanes below it), compacting sparse patterns.
  always_comb begin
    w_nvalid = '0;
    for (int k = 0; k < WPORT; k++) begin
      w_offset[k] = w_nvalid[INDEX-1:0];
      w_nvalid    = w_nvalid + (INDEX+1)'(wr_valid_i[k]);
    end
  end

  always_comb begin
    w_push    = ~reset & ~flush_i & ~w_stall;
    w_npush   = w_push ? w_nvalid : '0;
    w_pop_req = (INDEX+1)'(pop_cnt_i);
    w_npop    = w_pop_req;
    if (r_count < w_npop) w_npop = r_count;
    if (c_rport < w_npop) w_npop = c_rport;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        r_ram[d] <= '0;
      end
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_npop[INDEX-1:0];
      r_tail  <= r_tail + w_npush[INDEX-1:0];
      r_count <= r_count + w_npush - w_npop;
      for (int k = 0; k < WPORT; k++) begin
        if (w_push && wr_valid_i[k]) begin
          r_ram[r_tail + w_offset[k]] <= wr_data_i[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_data_o  = '0;
    rd_valid_o = '0;
    for (int i = 0; i < RPORT; i++) begin
      rd_data_o[i*WIDTH +: WIDTH] = r_ram[r_head + INDEX'(i)];
      rd_valid_o[i]               = (r_count > (INDEX+1)'(i));
    end
  end

  assign stall_o = w_stall;
  assign count_o = r_count;
  assign empty_o = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_ibuff_queue.sv
`default_nettype none
// Self-checking bench for ibuff_queue: vector table plus fill/drain, stall-boundary and wrap sequences.

module tb_ibuff_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic [3:0]  wr_valid_i;
  logic [31:0] wr_data_i;
  logic        stall_o;
  logic [2:0]  pop_cnt_i;
  logic [31:0] rd_data_o;
  logic [3:0]  rd_valid_o;
  logic [4:0]  count_o;
  logic        empty_o;

  int n_pass  = 0;
  int n_total = 0;

  ibuff_queue #(
    .WPORT (4),
    .RPORT (4),
    .DEPTH (16),
    .INDEX (4),
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush_i),
    .wr_valid_i (wr_valid_i),
    .wr_data_i  (wr_data_i),
    .stall_o    (stall_o),
    .pop_cnt_i  (pop_cnt_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .count_o    (count_o),
    .empty_o    (empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [3:0]  wv;
    logic [31:0] wd;
    logic [2:0]  pc;
    logic [4:0]  e_count;
    logic        e_stall;
    logic        e_empty;
    logic [3:0]  e_rv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic rst, logic fl, logic [3:0] wv, logic [31:0] wd, logic [2:0] pc,
                              logic [4:0] ec, logic es, logic ee, logic [3:0] erv, logic [31:0] erd);
    vec_t v;
    v.rst = rst; v.fl = fl; v.wv = wv; v.wd = wd; v.pc = pc;
    v.e_count = ec; v.e_stall = es; v.e_empty = ee; v.e_rv = erv; v.e_rd = erd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of stimulus at the falling edge, then let one rising edge consume it.
  task automatic step(input logic rst, input logic fl, input logic [3:0] wv,
                      input logic [31:0] wd, input logic [2:0] pc);
    @(negedge clk);
    reset = rst; flush_i = fl; wr_valid_i = wv; wr_data_i = wd; pc_drive(pc);
    @(posedge clk);
    #1;
  endtask

  task automatic pc_drive(input logic [2:0] pc);
    pop_cnt_i = pc;
  endtask

  task automatic check_state(input string tag, input logic [4:0] ec, input logic es,
                             input logic ee, input logic [3:0] erv, input logic [31:0] erd);
    check({tag, " count"}, 32'(count_o), 32'(ec));
    check({tag, " stall"}, 32'(stall_o), 32'(es));
    check({tag, " empty"}, 32'(empty_o), 32'(ee));
    check({tag, " rd_valid"}, 32'(rd_valid_o), 32'(erv));
    check({tag, " rd_data"}, rd_data_o, erd);
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; wr_valid_i = '0; wr_data_i = '0; pop_cnt_i = '0;

    //            rst  fl  wv       wd            pc  count stall empty rv       rd
    vecs[0]  = mk(1'b1,1'b0,4'b0000,32'h00000000,3'd0, 5'd0, 1'b0,1'b1,4'b0000,32'h00000000);
    vecs[1]  = mk(1'b0,1'b0,4'b1010,32'hD4C3B2A1,3'd0, 5'd2, 1'b0,1'b0,4'b0011,32'h0000D4B2);
    vecs[2]  = mk(1'b0,1'b0,4'b1111,32'h13121110,3'd0, 5'd6, 1'b0,1'b0,4'b1111,32'h1110D4B2);
    vecs[3]  = mk(1'b0,1'b0,4'b1111,32'h23222120,3'd4, 5'd6, 1'b0,1'b0,4'b1111,32'h21201312);
    vecs[4]  = mk(1'b0,1'b0,4'b1111,32'h33323130,3'd0, 5'd10,1'b0,1'b0,4'b1111,32'h21201312);
    vecs[5]  = mk(1'b0,1'b0,4'b1111,32'h43424140,3'd1, 5'd13,1'b1,1'b0,4'b1111,32'h22212013);
    vecs[6]  = mk(1'b0,1'b0,4'b1111,32'h53525150,3'd4, 5'd9, 1'b0,1'b0,4'b1111,32'h32313023);
    vecs[7]  = mk(1'b0,1'b0,4'b0001,32'h00000060,3'd4, 5'd6, 1'b0,1'b0,4'b1111,32'h42414033);
    vecs[8]  = mk(1'b0,1'b1,4'b1111,32'h77777777,3'd2, 5'd0, 1'b0,1'b1,4'b0000,32'h11604342);
    vecs[9]  = mk(1'b0,1'b0,4'b0011,32'h00009190,3'd0, 5'd2, 1'b0,1'b0,4'b0011,32'h11609190);
    vecs[10] = mk(1'b0,1'b0,4'b0000,32'h00000000,3'd4, 5'd0, 1'b0,1'b1,4'b0000,32'h13121160);
    vecs[11] = mk(1'b1,1'b0,4'b1111,32'hFFFFFFFF,3'd4, 5'd0, 1'b0,1'b1,4'b0000,32'h00000000);

    for (int v = 0; v < 12; v++) begin
      step(vecs[v].rst, vecs[v].fl, vecs[v].wv, vecs[v].wd, vecs[v].pc);
      check_state($sformatf("vec%0d", v), vecs[v].e_count, vecs[v].e_stall,
                  vecs[v].e_empty, vecs[v].e_rv, vecs[v].e_rd);
    end

    // Fill to 12, push+pop at the stall boundary, fill to full, then drain 4 per cycle.
    step(1'b1, 1'b0, 4'b0000, 32'h0, 3'd0);
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, 1'b0, 4'b1111, 32'h13121110, 3'd0);
      check($sformatf("fill%0d count", c), 32'(count_o), 32'(c * 4));
    end
    step(1'b0, 1'b0, 4'b1111, 32'h13121110, 3'd4);
    check("c12 push+pop count", 32'(count_o), 32'd12);
    step(1'b0, 1'b0, 4'b1111, 32'h13121110, 3'd0);
    check_state("full", 5'd16, 1'b1, 1'b0, 4'b1111, 32'h13121110);
    step(1'b0, 1'b0, 4'b1111, 32'hEEEEEEEE, 3'd0);
    check("full push ignored count", 32'(count_o), 32'd16);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("drain%0d window", c), rd_data_o, 32'h13121110);
      step(1'b0, 1'b0, 4'b0000, 32'h0, 3'd4);
      check($sformatf("drain%0d count", c), 32'(count_o), 32'(16 - c * 4));
    end
    check("drained empty", 32'(empty_o), 32'd1);

    // Walk head and tail to 14, then push across the wrap point.
    step(1'b1, 1'b0, 4'b0000, 32'h0, 3'd0);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 4'b1111, 32'h01010101, 3'd0);
    step(1'b0, 1'b0, 4'b0011, 32'h00000101, 3'd0);
    check("wrap pre count", 32'(count_o), 32'd14);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 4'b0000, 32'h0, 3'd4);
    step(1'b0, 1'b0, 4'b0000, 32'h0, 3'd2);
    check("wrap drained count", 32'(count_o), 32'd0);
    step(1'b0, 1'b0, 4'b1111, 32'hE3E2E1E0, 3'd0);
    check_state("wrap", 5'd4, 1'b0, 1'b0, 4'b1111, 32'hE3E2E1E0);
    step(1'b0, 1'b0, 4'b0000, 32'h0, 3'd2);
    check("wrap pop2 window", rd_data_o, 32'h0101E3E2);
    check("wrap pop2 valid", 32'(rd_valid_o), 32'h3);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
